mips_fetch_queue: RTL

//  Instruction-fetch front end for the MIPS32 pipeline. Issues word reads to instruction memory,

---
 rtl/mips_fetch_queue.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mips_fetch_queue.sv
// MIPS32 instruction-fetch front end: issues word reads, tracks in-flight requests,
// buffers returned words in an in-order queue and hands {IR, NPC} to ID.
module mips_fetch_queue #(
  parameter int AW      = 10,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                   clk1,
  input  logic                   rst,
  input  logic                   halt,
  input  logic                   redirect,
  input  logic [AW-1:0]          redirect_pc,
  output logic                   imem_req,
  output logic [AW-1:0]          imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  output logic                   id_valid,
  output logic [31:0]            id_ir,
  output logic [31:0]            id_npc,
  input  logic                   id_ready,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(MAX_OUT + 1);

  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] resp_pc_q, resp_pc_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] out_q, out_d;
  logic [OW-1:0] drop_q, drop_d;

  logic [31:0]   ir_mem  [DEPTH];
  logic [AW-1:0] npc_mem [DEPTH];

  logic [31:0] slots_used;
  logic        issue_ok;
  logic        fire;
  logic        resp;
  logic        push;
  logic        pop;

  // Queue slots are reserved at issue time, so a response can never find the queue full.
  assign slots_used = 32'(count_q) + 32'(out_q);
  assign issue_ok   = !halt && !redirect && (slots_used < 32'(DEPTH)) &&
                      (32'(out_q) < 32'(MAX_OUT));
  assign imem_req   = !rst && issue_ok;
  assign imem_addr  = pc_q;
  assign fire       = imem_req && imem_gnt;

  assign resp = imem_rvalid && (out_q != '0);
  assign push = resp && !redirect && (drop_q == '0);
  assign pop  = id_valid && id_ready && !redirect;

  assign id_valid = (count_q != '0);
  assign id_ir    = id_valid ? ir_mem[head_q] : 32'h0;
  assign id_npc   = id_valid ? {{(32-AW){1'b0}}, npc_mem[head_q]} : 32'h0;
  assign q_count  = count_q;

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    out_d     = out_q;
    drop_d    = drop_q;
    if (redirect) begin
      // Everything still in flight belongs to the old path and must be discarded.
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      out_d     = out_q - OW'(resp);
      drop_d    = out_q - OW'(resp);
    end else begin
      if (fire) begin
        pc_d = pc_q + AW'(1);
      end
      out_d = out_q + OW'(fire) - OW'(resp);
      if (resp && (drop_q != '0)) begin
        drop_d = drop_q - OW'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + AW'(1);
        tail_d    = tail_q + PW'(1);
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      pc_q      <= '0;
      resp_pc_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk1) begin
    if (!rst && push) begin
      ir_mem[tail_q]  <= imem_rdata;
      npc_mem[tail_q] <= resp_pc_q + AW'(1);
    end
  end

endmodule
